// File: rtl/spartan_expand.sv
// Narrow-to-wide 2x bus expander: pairs beats low-half-first into one registered
// double-width word, with an optional flush of a lone low half on DIN_LAST.
module spartan_expand #(
  parameter int unsigned INPUT_WIDTH = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [INPUT_WIDTH-1:0]     DIN,
  input  logic                       DIN_VAL,
  input  logic                       DIN_LAST,
  output logic                       DIN_RDY,
  output logic [2*INPUT_WIDTH-1:0]   DOUT,
  output logic                       DOUT_VAL,
  output logic                       DOUT_HALF,
  input  logic                       DOUT_RDY
);

  logic [INPUT_WIDTH-1:0]   lo_q, lo_d;
  logic                     lo_val_q, lo_val_d;
  logic [2*INPUT_WIDTH-1:0] out_q, out_d;
  logic                     out_half_q, out_half_d;
  logic                     out_val_q, out_val_d;
  logic                     out_free;
  logic                     accept;
  logic                     load;

  // A low-half beat never touches the output stage, so it may enter even while
  // the output is stalled; upper and flushing beats need a free output slot.
  always_comb begin
    out_free = !out_val_q || DOUT_RDY;
    DIN_RDY  = out_free || (!lo_val_q && !DIN_LAST);
    accept   = DIN_VAL && DIN_RDY;
    load     = accept && (lo_val_q || DIN_LAST);
  end

  always_comb begin
    lo_d       = lo_q;
    lo_val_d   = lo_val_q;
    out_d      = out_q;
    out_half_d = out_half_q;
    out_val_d  = out_val_q;
    if (accept) begin
      if (lo_val_q) begin
        out_d      = {DIN, lo_q};
        out_half_d = 1'b0;
        out_val_d  = 1'b1;
        lo_val_d   = 1'b0;
      end else if (DIN_LAST) begin
        out_d      = {{INPUT_WIDTH{1'b0}}, DIN};
        out_half_d = 1'b1;
        out_val_d  = 1'b1;
      end else begin
        lo_d     = DIN;
        lo_val_d = 1'b1;
      end
    end
    if (!load && out_val_q && DOUT_RDY) begin
      out_val_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lo_q       <= '0;
      lo_val_q   <= 1'b0;
      out_q      <= '0;
      out_half_q <= 1'b0;
      out_val_q  <= 1'b0;
    end else begin
      lo_q       <= lo_d;
      lo_val_q   <= lo_val_d;
      out_q      <= out_d;
      out_half_q <= out_half_d;
      out_val_q  <= out_val_d;
    end
  end

  assign DOUT      = out_q;
  assign DOUT_VAL  = out_val_q;
  assign DOUT_HALF = out_half_q;

endmodule

// File: tb/tb_spartan_expand.sv
// Directed bench for spartan_expand (W=32): streaming, backpressure, flush,
// blocked flush and mid-word reset, with hand-computed expected words.
module tb_spartan_expand;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] DIN = '0;
  logic        DIN_VAL = 1'b0;
  logic        DIN_LAST = 1'b0;
  logic        DIN_RDY;
  logic [63:0] DOUT;
  logic        DOUT_VAL;
  logic        DOUT_HALF;
  logic        DOUT_RDY = 1'b1;

  int total = 0;
  int bad = 0;

  spartan_expand #(.INPUT_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VAL(DIN_VAL), .DIN_LAST(DIN_LAST),
    .DIN_RDY(DIN_RDY), .DOUT(DOUT), .DOUT_VAL(DOUT_VAL), .DOUT_HALF(DOUT_HALF),
    .DOUT_RDY(DOUT_RDY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    DIN_VAL = v; DIN = d; DIN_LAST = l;
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (DOUT !== 64'h0) begin $display("FAIL reset_dout got %h want %h", DOUT, 64'h0); bad++; end
    total++; if (DOUT_VAL !== 1'b0) begin $display("FAIL reset_val got %b want 0", DOUT_VAL); bad++; end
    total++; if (DOUT_HALF !== 1'b0) begin $display("FAIL reset_half got %b want 0", DOUT_HALF); bad++; end
    total++; if (DIN_RDY !== 1'b1) begin $display("FAIL reset_rdy got %b want 1", DIN_RDY); bad++; end
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic test_stream();
    DOUT_RDY = 1'b1;
    drive(1'b1, 32'h11111111, 1'b0);
    total++; if (DIN_RDY !== 1'b1) begin $display("FAIL stream_rdy1 got %b want 1", DIN_RDY); bad++; end
    tick();
    total++; if (DOUT_VAL !== 1'b0) begin $display("FAIL stream_val1 got %b want 0", DOUT_VAL); bad++; end
    drive(1'b1, 32'h22222222, 1'b0);
    total++; if (DIN_RDY !== 1'b1) begin $display("FAIL stream_rdy2 got %b want 1", DIN_RDY); bad++; end
    tick();
    total++; if (DOUT !== 64'h2222222211111111 || DOUT_VAL !== 1'b1 || DOUT_HALF !== 1'b0)
      begin $display("FAIL stream_w1 got %h/%b/%b want 2222222211111111/1/0", DOUT, DOUT_VAL, DOUT_HALF); bad++; end
    drive(1'b1, 32'h33333333, 1'b0);
    total++; if (DIN_RDY !== 1'b1) begin $display("FAIL stream_rdy3 got %b want 1", DIN_RDY); bad++; end
    tick();
    total++; if (DOUT_VAL !== 1'b0) begin $display("FAIL stream_val3 got %b want 0", DOUT_VAL); bad++; end
    drive(1'b1, 32'h44444444, 1'b0);
    total++; if (DIN_RDY !== 1'b1) begin $display("FAIL stream_rdy4 got %b want 1", DIN_RDY); bad++; end
    tick();
    total++; if (DOUT !== 64'h4444444433333333 || DOUT_VAL !== 1'b1 || DOUT_HALF !== 1'b0)
      begin $display("FAIL stream_w2 got %h/%b/%b want 4444444433333333/1/0", DOUT, DOUT_VAL, DOUT_HALF); bad++; end
    drive(1'b0, 32'h0, 1'b0);
    tick();
    total++; if (DOUT_VAL !== 1'b0) begin $display("FAIL stream_drain got %b want 0", DOUT_VAL); bad++; end
  endtask

  task automatic test_backpressure();
    DOUT_RDY = 1'b1;
    drive(1'b1, 32'h11111111, 1'b0);
    tick();
    drive(1'b1, 32'h22222222, 1'b0);
    tick();
    DOUT_RDY = 1'b0;
    drive(1'b1, 32'h33333333, 1'b0);
    total++; if (DIN_RDY !== 1'b1) begin $display("FAIL bp_lo_rdy got %b want 1", DIN_RDY); bad++; end
    tick();
    drive(1'b1, 32'h44444444, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++; if (DOUT !== 64'h2222222211111111 || DOUT_VAL !== 1'b1)
        begin $display("FAIL bp_hold%0d got %h/%b want 2222222211111111/1", i, DOUT, DOUT_VAL); bad++; end
      total++; if (DIN_RDY !== 1'b0) begin $display("FAIL bp_stall%0d got %b want 0", i, DIN_RDY); bad++; end
      if (i < 2) tick();
    end
    DOUT_RDY = 1'b1;
    #1;
    total++; if (DIN_RDY !== 1'b1) begin $display("FAIL bp_release got %b want 1", DIN_RDY); bad++; end
    tick();
    total++; if (DOUT !== 64'h4444444433333333 || DOUT_VAL !== 1'b1 || DOUT_HALF !== 1'b0)
      begin $display("FAIL bp_w2 got %h/%b/%b want 4444444433333333/1/0", DOUT, DOUT_VAL, DOUT_HALF); bad++; end
    drive(1'b0, 32'h0, 1'b0);
    tick();
    total++; if (DOUT_VAL !== 1'b0) begin $display("FAIL bp_drain got %b want 0", DOUT_VAL); bad++; end
  endtask

  task automatic test_flush();
    DOUT_RDY = 1'b1;
    drive(1'b1, 32'hAAAAAAAA, 1'b1);
    total++; if (DIN_RDY !== 1'b1) begin $display("FAIL flush_rdy got %b want 1", DIN_RDY); bad++; end
    tick();
    total++; if (DOUT !== 64'h00000000AAAAAAAA || DOUT_VAL !== 1'b1 || DOUT_HALF !== 1'b1)
      begin $display("FAIL flush_word got %h/%b/%b want 00000000aaaaaaaa/1/1", DOUT, DOUT_VAL, DOUT_HALF); bad++; end
    drive(1'b1, 32'h0000000B, 1'b0);
    tick();
    total++; if (DOUT_VAL !== 1'b0) begin $display("FAIL flush_lo got %b want 0", DOUT_VAL); bad++; end
    drive(1'b1, 32'h0000000C, 1'b0);
    tick();
    total++; if (DOUT !== 64'h0000000C0000000B || DOUT_VAL !== 1'b1 || DOUT_HALF !== 1'b0)
      begin $display("FAIL flush_pair got %h/%b/%b want 0000000c0000000b/1/0", DOUT, DOUT_VAL, DOUT_HALF); bad++; end
    drive(1'b0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_last_upper();
    DOUT_RDY = 1'b1;
    drive(1'b1, 32'h1, 1'b0);
    tick();
    drive(1'b1, 32'h2, 1'b1);
    tick();
    total++; if (DOUT !== 64'h0000000200000001 || DOUT_VAL !== 1'b1 || DOUT_HALF !== 1'b0)
      begin $display("FAIL lastup_word got %h/%b/%b want 0000000200000001/1/0", DOUT, DOUT_VAL, DOUT_HALF); bad++; end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    total++; if (DOUT_VAL !== 1'b0) begin $display("FAIL lastup_extra1 got %b want 0", DOUT_VAL); bad++; end
    tick();
    total++; if (DOUT_VAL !== 1'b0) begin $display("FAIL lastup_extra2 got %b want 0", DOUT_VAL); bad++; end
    drive(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_flush_blocked();
    DOUT_RDY = 1'b1;
    drive(1'b1, 32'h3, 1'b0);
    tick();
    drive(1'b1, 32'h4, 1'b0);
    tick();
    DOUT_RDY = 1'b0;
    drive(1'b1, 32'hF0F0F0F0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      total++; if (DIN_RDY !== 1'b0) begin $display("FAIL fblk_stall%0d got %b want 0", i, DIN_RDY); bad++; end
      total++; if (DOUT !== 64'h0000000400000003 || DOUT_VAL !== 1'b1 || DOUT_HALF !== 1'b0)
        begin $display("FAIL fblk_hold%0d got %h/%b/%b want 0000000400000003/1/0", i, DOUT, DOUT_VAL, DOUT_HALF); bad++; end
      tick();
      #1;
    end
    DOUT_RDY = 1'b1;
    #1;
    total++; if (DIN_RDY !== 1'b1) begin $display("FAIL fblk_release got %b want 1", DIN_RDY); bad++; end
    tick();
    total++; if (DOUT !== 64'h00000000F0F0F0F0 || DOUT_VAL !== 1'b1 || DOUT_HALF !== 1'b1)
      begin $display("FAIL fblk_word got %h/%b/%b want 00000000f0f0f0f0/1/1", DOUT, DOUT_VAL, DOUT_HALF); bad++; end
    drive(1'b0, 32'h0, 1'b0);
    tick();
    total++; if (DOUT_VAL !== 1'b0) begin $display("FAIL fblk_drain got %b want 0", DOUT_VAL); bad++; end
  endtask

  task automatic test_reset_mid();
    DOUT_RDY = 1'b1;
    drive(1'b1, 32'h8, 1'b0);
    tick();
    DOUT_RDY = 1'b0;
    drive(1'b1, 32'h9, 1'b0);
    tick();
    drive(1'b1, 32'h5, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    total++; if (DOUT_VAL !== 1'b1) begin $display("FAIL rmid_pre got %b want 1", DOUT_VAL); bad++; end
    RST = 1'b1;
    #1;
    total++; if (DOUT_VAL !== 1'b0 || DOUT !== 64'h0) begin $display("FAIL rmid_async got %b/%h want 0/0", DOUT_VAL, DOUT); bad++; end
    tick();
    RST = 1'b0;
    DOUT_RDY = 1'b1;
    drive(1'b1, 32'h6, 1'b0);
    tick();
    total++; if (DOUT_VAL !== 1'b0) begin $display("FAIL rmid_lo got %b want 0", DOUT_VAL); bad++; end
    drive(1'b1, 32'h7, 1'b0);
    tick();
    total++; if (DOUT !== 64'h0000000700000006 || DOUT_VAL !== 1'b1 || DOUT_HALF !== 1'b0)
      begin $display("FAIL rmid_word got %h/%b/%b want 0000000700000006/1/0", DOUT, DOUT_VAL, DOUT_HALF); bad++; end
    drive(1'b0, 32'h0, 1'b0);
    tick();
  endtask

  initial begin
    test_reset();
    tick();
    test_stream();
    test_backpressure();
    test_flush();
    test_last_upper();
    test_flush_blocked();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
